audio_reg_slave: RTL and testbench
==================================

// Module: audio_reg_slave
// PURPOSE
//  - Write-only AXI-lite-style slave at the downstream end of the control write master's
//    AW/W/B channels.
//  - Captures one address/data pair per transaction and commits it to a bank of audio
//    control registers (volume, balance, mute and similar), then returns a write response.
//  - The register contents drive the audio datapath configuration inputs.
// PARAMETERS
//  ADDR_W     4    AWADDR width
//  DATA_W     7    WDATA / register width
//  NUM_REGS   12   implemented registers, addresses 0..NUM_REGS-1; must be <= 2**ADDR_W
//  ERRCNT_W   8    width of the saturating bad-address counter
// PORTS
//  ACLK         in   1                 clock, all logic rising-edge
//  ARESET       in   1                 synchronous reset, active-high
//  AWVALID      in   1                 write address valid
//  AWADDR       in   ADDR_W            write address
//  AWREADY      out  1                 write address ready
//  WVALID       in   1                 write data valid
//  WDATA        in   DATA_W            write data
//  WREADY       out  1                 write data ready
//  BVALID       out  1                 write response valid
//  BREADY       in   1                 write response ready
//  reg_q        out  NUM_REGS*DATA_W   register contents; reg i at [i*DATA_W +: DATA_W]
//  wr_stb       out  1                 1-cycle pulse: a register was updated this cycle
//  wr_addr      out  ADDR_W            address of the last accepted write (valid with wr_stb)
//  bad_addr_cnt out  ERRCNT_W          count of writes to address >= NUM_REGS, saturating
// BEHAVIOUR
//  Reset (sync, ARESET=1 at an edge): state=IDLE; AWREADY=WREADY=BVALID=wr_stb=0;
//    wr_addr=0, all reg_q=0, bad_addr_cnt=0. Applies mid-transaction; no write is committed.
//    BVALID drops at that edge.
//  All outputs are registered; there is no combinational path from input to output.
//  FSM states: IDLE, ACCEPT, RESP, TURN.
//  - IDLE: AWREADY=WREADY=0, BVALID=0.
//    AWVALID&WVALID at an edge -> ACCEPT. Only one valid high -> stay in IDLE; nothing is latched.
//  - ACCEPT (exactly 1 cycle): AWREADY=WREADY=1, both asserted in the same cycle.
//    The master requires simultaneous readies.
//    At the closing edge: latch AWADDR/WDATA.
//    If addr < NUM_REGS: write the register, wr_stb=1 next cycle, wr_addr=addr.
//    Else: no register change, wr_stb=0, bad_addr_cnt += 1 (holds at all-ones).
//    Always go to RESP.
//  - RESP: BVALID=1, held until BREADY=1 at an edge -> TURN.
//    BVALID is held stable while BREADY=0 with no timeout.
//  - TURN (exactly 1 cycle): all readies 0, BVALID=0 -> IDLE.
//    Required: the master keeps AWVALID/WVALID high between transactions and loads the
//    next payload one cycle after the B handshake. TURN prevents re-accepting a stale pair.
//  Latency: valids seen at edge N -> readies high cycle N+1 -> reg_q/wr_stb updated and
//    BVALID high from cycle N+2.
//    Min transaction = 4 cycles with BREADY already high (IDLE, ACCEPT, RESP, TURN).
//  Valids dropped during ACCEPT: protocol violation. The transfer still completes with
//    the values sampled at the ACCEPT edge.
//  wr_stb is high for exactly one cycle per in-range write, aligned with the new reg_q value.
//  No read channel and no BRESP. An out-of-range write is reported only via bad_addr_cnt.
// STRUCTURE
//  - audio_axi_pkg.vh (shared with the write master):
//    - ADDR_W/DATA_W defaults
//    - FSM state encodings for IDLE/ACCEPT/RESP/TURN (2 bits)
//    - register index localparams, e.g. REG_VOL_L=0, REG_VOL_R=1, REG_MUTE=2
//  - Sub-module audio_reg_bank:
//    - NUM_REGS x DATA_W array with sync reset
//    - inputs: we, waddr, wdata; outputs: flattened reg_q, wr_stb
//  - Top-level keeps the FSM, handshake regs and bad_addr_cnt.
// TESTING
//  1. Reset, then AWVALID=WVALID=1, AWADDR=3, WDATA=7'h55, BREADY=1.
//     -> AWREADY&WREADY high together for 1 cycle.
//     -> reg 3 = 55h and wr_stb=1 in the same cycle that BVALID rises.
//     -> BVALID high 1 cycle, then TURN.
//  2. Valids held high, payload switches (addr 3 -> 4, data 55h -> 2Ah) one cycle after the
//     B handshake.
//     -> the second accept latches addr 4 / 2Ah.
//     -> reg 3 is not rewritten.
//  3. AWVALID=1 with WVALID=0 for 5 cycles, then WVALID=1.
//     -> no ready during those 5 cycles.
//     -> accept occurs one cycle after both valids are high.
//  4. Write AWADDR=14 (>= NUM_REGS) with data 7Fh.
//     -> BVALID still returned, reg_q unchanged, wr_stb=0, bad_addr_cnt=1.
//     -> after 300 such writes, bad_addr_cnt=255.
//  5. BREADY=0 for 10 cycles during RESP.
//     -> BVALID stays 1, no new ready.
//     -> BREADY=1 -> BVALID low next edge.
//  6. ARESET=1 for 1 cycle while in RESP after writing reg 0 = 12h.
//     -> next cycle: BVALID=0, reg 0=0, state IDLE.
//     -> a following write completes normally.

Source files
------------

// File: rtl/audio_axi_pkg.sv
// Shared definitions for the audio control write path: bus widths, FSM encodings
// and register map indices used by both the write master and the register slave.
package audio_axi_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_RESP   = 2'd2,
        ST_TURN   = 2'd3
    } wr_state_e;

    localparam int REG_VOL_L   = 0;
    localparam int REG_VOL_R   = 1;
    localparam int REG_MUTE    = 2;
    localparam int REG_BALANCE = 3;
    localparam int REG_BASS    = 4;
    localparam int REG_TREBLE  = 5;

endpackage

// File: rtl/audio_reg_bank.sv
// Bank of audio control registers with a one-cycle write strobe aligned to
// the updated register contents.
module audio_reg_bank
    import audio_axi_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_stb
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_stb_q;
    logic              wr_stb_d;

    // Next register contents: only the addressed entry changes on a write.
    always_comb begin
        regs_d   = regs_q;
        wr_stb_d = we;
        if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs_d[i] = wdata;
                end else begin
                    regs_d[i] = regs_q[i];
                end
            end
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage and strobe flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '{default: '0};
            wr_stb_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_stb_q <= wr_stb_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_stb = wr_stb_q;

endmodule

// File: rtl/audio_reg_slave.sv
// Write-only AXI-lite-style slave that commits one address/data pair per
// transaction into the audio control register bank.
module audio_reg_slave
    import audio_axi_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 12,
    parameter int ERRCNT_W = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         AWVALID,
    input  logic [ADDR_W-1:0]            AWADDR,
    output logic                         AWREADY,
    input  logic                         WVALID,
    input  logic [DATA_W-1:0]            WDATA,
    output logic                         WREADY,
    output logic                         BVALID,
    input  logic                         BREADY,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [ERRCNT_W-1:0]          bad_addr_cnt
);

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    wr_state_e             state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  bvalid_q, bvalid_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [ERRCNT_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic                  bank_we;
    logic                  addr_ok;

    assign addr_ok = ({1'b0, AWADDR} < NUM_REGS_W);

    // Next-state and registered-output decode for the write handshake.
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        bvalid_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        bad_cnt_d = bad_cnt_q;
        bank_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AWVALID && WVALID) begin
                    state_d = ST_ACCEPT;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                state_d  = ST_RESP;
                bvalid_d = 1'b1;
                if (addr_ok) begin
                    bank_we   = 1'b1;
                    wr_addr_d = AWADDR;
                end else if (bad_cnt_q != {ERRCNT_W{1'b1}}) begin
                    bad_cnt_d = bad_cnt_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
                end else begin
                    bad_cnt_d = bad_cnt_q;
                end
            end
            ST_RESP: begin
                if (BREADY) begin
                    state_d = ST_TURN;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and handshake/status flops.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            bad_cnt_q <= {ERRCNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            bvalid_q  <= bvalid_d;
            wr_addr_q <= wr_addr_d;
            bad_cnt_q <= bad_cnt_d;
        end
    end

    audio_reg_bank #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk    (ACLK),
        .rst    (ARESET),
        .we     (bank_we),
        .waddr  (AWADDR),
        .wdata  (WDATA),
        .reg_q  (reg_q),
        .wr_stb (wr_stb)
    );

    assign AWREADY      = ready_q;
    assign WREADY       = ready_q;
    assign BVALID       = bvalid_q;
    assign wr_addr      = wr_addr_q;
    assign bad_addr_cnt = bad_cnt_q;

endmodule

// File: tb/tb_audio_reg_slave.sv
// Scoreboard bench for audio_reg_slave: expected writes are queued when driven and
// retired against the register bank, strobe and error counter when BVALID rises.
module tb_audio_reg_slave;

    localparam int AW = 4;
    localparam int DW = 7;
    localparam int NR = 12;
    localparam int EW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic              ACLK;
    logic              ARESET;
    logic              AWVALID;
    logic [AW-1:0]     AWADDR;
    logic              AWREADY;
    logic              WVALID;
    logic [DW-1:0]     WDATA;
    logic              WREADY;
    logic              BVALID;
    logic              BREADY;
    logic [NR*DW-1:0]  reg_q;
    logic              wr_stb;
    logic [AW-1:0]     wr_addr;
    logic [EW-1:0]     bad_addr_cnt;

    exp_t              sb_q[$];
    logic [NR*DW-1:0]  model_regs;
    logic [AW-1:0]     model_wr_addr;
    logic [EW-1:0]     model_bad;
    int                n_tests;
    int                n_fail;

    audio_reg_slave #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .ERRCNT_W (EW)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .AWVALID      (AWVALID),
        .AWADDR       (AWADDR),
        .AWREADY      (AWREADY),
        .WVALID       (WVALID),
        .WDATA        (WDATA),
        .WREADY       (WREADY),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .reg_q        (reg_q),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .bad_addr_cnt (bad_addr_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_reset;
        model_regs    = '0;
        model_wr_addr = '0;
        model_bad     = '0;
        sb_q.delete();
    endtask

    // One full transaction; exp_wait = edges until readies, stall = cycles BREADY held low.
    task automatic write_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int exp_wait, input int stall);
        exp_t e;
        int   waited;
        logic exp_stb;
        AWADDR  = addr;
        WDATA   = data;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = (stall == 0);
        e.addr  = addr;
        e.data  = data;
        sb_q.push_back(e);
        waited = 0;
        while (!(AWREADY || WREADY) && waited < 20) begin
            tick;
            waited++;
        end
        n_tests++;
        if (waited !== exp_wait) begin
            n_fail++;
            $display("FAIL accept_wait addr=%0d: got %0d cycles, expected %0d", addr, waited, exp_wait);
        end
        if (!(AWREADY || WREADY)) begin
            void'(sb_q.pop_front());
            return;
        end
        n_tests++;
        if ({AWREADY, WREADY, BVALID} !== 3'b110) begin
            n_fail++;
            $display("FAIL accept_readies: got AWREADY/WREADY/BVALID=%b, expected 110", {AWREADY, WREADY, BVALID});
        end
        tick;
        e = sb_q.pop_front();
        exp_stb = (e.addr < AW'(NR));
        if (exp_stb) begin
            model_regs[e.addr*DW +: DW] = e.data;
            model_wr_addr = e.addr;
        end else if (model_bad != 8'hFF) begin
            model_bad = model_bad + 8'd1;
        end
        n_tests++;
        if ({AWREADY, WREADY, BVALID, wr_stb} !== {3'b001, exp_stb}) begin
            n_fail++;
            $display("FAIL resp_flags addr=%0d: got AWREADY/WREADY/BVALID/wr_stb=%b, expected %b",
                     e.addr, {AWREADY, WREADY, BVALID, wr_stb}, {3'b001, exp_stb});
        end
        n_tests++;
        if (reg_q !== model_regs || wr_addr !== model_wr_addr || bad_addr_cnt !== model_bad) begin
            n_fail++;
            $display("FAIL commit addr=%0d: got reg_q=%h wr_addr=%0d bad=%0d, expected reg_q=%h wr_addr=%0d bad=%0d",
                     e.addr, reg_q, wr_addr, bad_addr_cnt, model_regs, model_wr_addr, model_bad);
        end
        for (int i = 0; i < stall; i++) begin
            tick;
            n_tests++;
            if ({BVALID, AWREADY, WREADY, wr_stb} !== 4'b1000) begin
                n_fail++;
                $display("FAIL resp_hold cycle %0d: got BVALID/AWREADY/WREADY/wr_stb=%b, expected 1000",
                         i, {BVALID, AWREADY, WREADY, wr_stb});
            end
        end
        BREADY = 1'b1;
        tick;
        n_tests++;
        if ({BVALID, AWREADY, WREADY, wr_stb} !== 4'b0000) begin
            n_fail++;
            $display("FAIL turn: got BVALID/AWREADY/WREADY/wr_stb=%b, expected 0000",
                     {BVALID, AWREADY, WREADY, wr_stb});
        end
    endtask

    task automatic test_reset;
        ARESET  = 1'b1;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        AWADDR  = '0;
        WDATA   = '0;
        BREADY  = 1'b1;
        model_reset();
        tick;
        tick;
        ARESET = 1'b0;
        n_tests++;
        if ({AWREADY, WREADY, BVALID, wr_stb} !== 4'b0000 || reg_q !== model_regs ||
            wr_addr !== model_wr_addr || bad_addr_cnt !== model_bad) begin
            n_fail++;
            $display("FAIL reset_state: got flags=%b reg_q=%h wr_addr=%0d bad=%0d, expected 0000/0/0/0",
                     {AWREADY, WREADY, BVALID, wr_stb}, reg_q, wr_addr, bad_addr_cnt);
        end
    endtask

    task automatic test_basic_write;
        write_txn(4'd3, 7'h55, 1, 0);
    endtask

    task automatic test_back_to_back;
        write_txn(4'd4, 7'h2A, 2, 0);
        n_tests++;
        if (reg_q[3*DW +: DW] !== 7'h55) begin
            n_fail++;
            $display("FAIL reg3_kept: got %h, expected 55", reg_q[3*DW +: DW]);
        end
    endtask

    task automatic test_valid_wait;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        tick;
        tick;
        AWVALID = 1'b1;
        AWADDR  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_tests++;
            if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
                n_fail++;
                $display("FAIL half_valid cycle %0d: got AWREADY/WREADY/BVALID=%b, expected 000",
                         i, {AWREADY, WREADY, BVALID});
            end
        end
        write_txn(4'd5, 7'h11, 1, 0);
    endtask

    task automatic test_bad_addr;
        write_txn(4'd14, 7'h7F, 2, 0);
        n_tests++;
        if (bad_addr_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL bad_cnt_first: got %0d, expected 1", bad_addr_cnt);
        end
        for (int i = 1; i < 300; i++) begin
            write_txn(AW'($urandom_range(12, 15)), DW'($urandom), 2, 0);
        end
        n_tests++;
        if (bad_addr_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL bad_cnt_saturate: got %0d, expected 255", bad_addr_cnt);
        end
    endtask

    task automatic test_bready_stall;
        write_txn(4'd6, 7'h33, 2, 10);
    endtask

    task automatic test_reset_mid;
        int waited;
        AWADDR  = 4'd0;
        WDATA   = 7'h12;
        BREADY  = 1'b0;
        waited  = 0;
        while (!AWREADY && waited < 20) begin
            tick;
            waited++;
        end
        tick;
        n_tests++;
        if (BVALID !== 1'b1 || reg_q[DW-1:0] !== 7'h12) begin
            n_fail++;
            $display("FAIL pre_reset_resp: got BVALID=%b reg0=%h, expected 1/12", BVALID, reg_q[DW-1:0]);
        end
        ARESET = 1'b1;
        tick;
        ARESET = 1'b0;
        model_reset();
        n_tests++;
        if ({AWREADY, WREADY, BVALID, wr_stb} !== 4'b0000 || reg_q !== model_regs ||
            bad_addr_cnt !== model_bad || wr_addr !== model_wr_addr) begin
            n_fail++;
            $display("FAIL mid_reset: got flags=%b reg_q=%h bad=%0d wr_addr=%0d, expected 0000/0/0/0",
                     {AWREADY, WREADY, BVALID, wr_stb}, reg_q, bad_addr_cnt, wr_addr);
        end
        write_txn(4'd7, 7'h4C, 1, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic_write();
        test_back_to_back();
        test_valid_wait();
        test_bad_addr();
        test_bready_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
